inst_fetch: RTL and testbench

// - IF stage of the 5-stage RV64I pipeline, directly upstream of inst_decode.
// - Owns the fetch PC and drives the instruction-memory request/response handshake.
// - Presents one 32-bit instruction plus its PC per cycle to decode.
// - Resolves JAL targets locally; applies branch/JALR redirects from later stages; holds on decode load-use stalls.

---
 rtl/rv_pkg.sv | 29 ++
 rtl/fetch_skid_buf.sv | 36 +++
 rtl/inst_fetch.sv | 118 +++++++++++
 tb/tb_inst_fetch.sv | 153 +++++++++++++++
 4 files changed

// File: rtl/rv_pkg.sv
// Shared RV64I pipeline definitions: opcodes, bubble word, reset PC and
// fetch-stage FSM encoding.
package rv_pkg;

  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_REG    = 7'b0110011;

  localparam logic [31:0] NOP_INST         = 32'h0000_0013;
  localparam logic [63:0] RESET_PC_DEFAULT = 64'h0000_0000_8000_0000;

  typedef enum logic [1:0] {
    FS_IDLE = 2'd0,
    FS_REQ  = 2'd1,
    FS_DROP = 2'd2
  } fetch_state_e;

  typedef struct packed {
    logic [63:0] pc;
    logic [31:0] inst;
  } fetch_word_t;

endpackage

// File: rtl/fetch_skid_buf.sv
// One-entry {pc,inst} holding buffer for a word that returns while decode
// is stalled. Flush beats push beats pop.
module fetch_skid_buf
  import rv_pkg::*;
(
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        push_i,
  input  logic        pop_i,
  input  logic        flush_i,
  input  fetch_word_t data_i,
  output logic        valid_o,
  output fetch_word_t data_o
);

  logic        valid_q;
  fetch_word_t data_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      valid_q <= 1'b0;
      data_q  <= '0;
    end else if (flush_i) begin
      valid_q <= 1'b0;
    end else if (push_i) begin
      valid_q <= 1'b1;
      data_q  <= data_i;
    end else if (pop_i) begin
      valid_q <= 1'b0;
    end
  end

  assign valid_o = valid_q;
  assign data_o  = data_q;

endmodule

// File: rtl/inst_fetch.sv
// IF stage: owns the fetch PC, runs the imem handshake, resolves JAL locally
// and presents one registered instruction/PC pair per cycle to decode.
module inst_fetch #(
  parameter logic [63:0] RESET_PC = rv_pkg::RESET_PC_DEFAULT,
  parameter logic [31:0] NOP_INST = rv_pkg::NOP_INST
) (
  input  logic        CLK,
  input  logic        reset,
  output logic        imem_req,
  output logic [63:0] imem_addr,
  input  logic        imem_ready,
  input  logic [31:0] imem_rdata,
  input  logic        hold_i,
  input  logic        redirect_en,
  input  logic [63:0] redirect_pc,
  output logic [31:0] inst,
  output logic [63:0] pc_o,
  output logic        bubble_o
);
  import rv_pkg::*;

  fetch_state_e state_q, state_d;
  logic [63:0]  fetch_pc_q, fetch_pc_d;
  logic [31:0]  inst_q, inst_d;
  logic [63:0]  pc_q, pc_d;
  logic         bubble_q, bubble_d;

  logic         accept;
  logic         skid_valid, skid_push, skid_pop;
  fetch_word_t  skid_word, fetch_word;
  logic [63:0]  jal_imm, next_pc;

  // No new request while the skid holds a word, so it can never overflow.
  assign imem_req  = (state_q == FS_REQ) && !skid_valid;
  assign imem_addr = fetch_pc_q;
  assign accept    = imem_req && imem_ready;

  assign fetch_word.pc   = fetch_pc_q;
  assign fetch_word.inst = imem_rdata;

  assign jal_imm = {{43{imem_rdata[31]}}, imem_rdata[31], imem_rdata[19:12],
                    imem_rdata[20], imem_rdata[30:21], 1'b0};
  assign next_pc = (imem_rdata[6:0] == OP_JAL) ? fetch_pc_q + jal_imm
                                               : fetch_pc_q + 64'd4;

  assign skid_push = accept && hold_i && !redirect_en;
  assign skid_pop  = skid_valid && !hold_i && !redirect_en;

  fetch_skid_buf u_skid (
    .clk_i   (CLK),
    .rst_ni  (reset),
    .push_i  (skid_push),
    .pop_i   (skid_pop),
    .flush_i (redirect_en),
    .data_i  (fetch_word),
    .valid_o (skid_valid),
    .data_o  (skid_word)
  );

  always_comb begin
    state_d    = state_q;
    fetch_pc_d = fetch_pc_q;
    inst_d     = inst_q;
    pc_d       = pc_q;
    bubble_d   = bubble_q;

    if (accept) fetch_pc_d = next_pc;

    case (state_q)
      FS_IDLE: state_d = FS_REQ;
      FS_REQ:  state_d = FS_REQ;
      FS_DROP: if (imem_ready) state_d = FS_REQ;
      default: state_d = FS_IDLE;
    endcase

    if (redirect_en) begin
      fetch_pc_d = {redirect_pc[63:2], 2'b00};
      inst_d     = NOP_INST;
      bubble_d   = 1'b1;
      // A request the memory already owns must be drained before refetching.
      if (imem_req && !imem_ready) state_d = FS_DROP;
    end else if (!hold_i) begin
      if (skid_valid) begin
        pc_d     = skid_word.pc;
        inst_d   = skid_word.inst;
        bubble_d = 1'b0;
      end else if (accept) begin
        pc_d     = fetch_pc_q;
        inst_d   = imem_rdata;
        bubble_d = 1'b0;
      end else begin
        inst_d   = NOP_INST;
        bubble_d = 1'b1;
      end
    end
  end

  always_ff @(posedge CLK or negedge reset) begin
    if (!reset) begin
      state_q    <= FS_IDLE;
      fetch_pc_q <= RESET_PC;
      inst_q     <= NOP_INST;
      pc_q       <= '0;
      bubble_q   <= 1'b1;
    end else begin
      state_q    <= state_d;
      fetch_pc_q <= fetch_pc_d;
      inst_q     <= inst_d;
      pc_q       <= pc_d;
      bubble_q   <= bubble_d;
    end
  end

  assign inst     = inst_q;
  assign pc_o     = pc_q;
  assign bubble_o = bubble_q;

endmodule

// File: tb/tb_inst_fetch.sv
// Directed vector bench for inst_fetch: per-cycle table of inputs and the
// outputs expected during that cycle, plus an async-reset sequence.
module tb_inst_fetch;

  localparam logic [31:0] NOP = 32'h0000_0013;
  localparam logic [31:0] A0  = 32'h0010_0093;
  localparam logic [31:0] A1  = 32'h0020_0113;
  localparam logic [31:0] A2  = 32'h0030_0193;
  localparam logic [31:0] A3  = 32'h0040_0213;
  localparam logic [31:0] JAL = 32'h0100_006F;
  localparam logic [63:0] TOP = 64'hFFFF_FFFF_FFFF_FFFC;
  localparam int NV = 23;

  logic        CLK = 1'b0;
  logic        reset = 1'b1;
  logic        imem_req;
  logic [63:0] imem_addr;
  logic        imem_ready = 1'b0;
  logic [31:0] imem_rdata = '0;
  logic        hold_i = 1'b0;
  logic        redirect_en = 1'b0;
  logic [63:0] redirect_pc = '0;
  logic [31:0] inst;
  logic [63:0] pc_o;
  logic        bubble_o;

  int n_cmp = 0;
  int n_err = 0;

  typedef struct {
    logic        hold;
    logic        redir;
    logic [63:0] rpc;
    logic        rdy;
    logic [31:0] w;
    logic        e_req;
    logic [63:0] e_addr;
    logic [31:0] e_inst;
    logic [63:0] e_pc;
    logic        e_bub;
  } vec_t;

  vec_t vec [NV];

  inst_fetch dut (
    .CLK         (CLK),
    .reset       (reset),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_ready  (imem_ready),
    .imem_rdata  (imem_rdata),
    .hold_i      (hold_i),
    .redirect_en (redirect_en),
    .redirect_pc (redirect_pc),
    .inst        (inst),
    .pc_o        (pc_o),
    .bubble_o    (bubble_o)
  );

  always #5 CLK = ~CLK;

  function automatic vec_t mk(logic h, logic r, logic [63:0] rp, logic rd, logic [31:0] w,
                              logic er, logic [63:0] ea, logic [31:0] ei, logic [63:0] ep,
                              logic eb);
    vec_t v;
    v.hold = h; v.redir = r; v.rpc = rp; v.rdy = rd; v.w = w;
    v.e_req = er; v.e_addr = ea; v.e_inst = ei; v.e_pc = ep; v.e_bub = eb;
    return v;
  endfunction

  task automatic chk(input string name, input int row, input logic [63:0] act,
                     input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s step %0d: got %h expected %h", name, row, act, exp);
    end
  endtask

  task automatic chk_all(input int row, input logic er, input logic [63:0] ea,
                         input logic [31:0] ei, input logic [63:0] ep, input logic eb);
    chk("imem_req", row, 64'(imem_req), 64'(er));
    chk("imem_addr", row, imem_addr, ea);
    chk("inst", row, 64'(inst), 64'(ei));
    chk("pc_o", row, pc_o, ep);
    chk("bubble_o", row, 64'(bubble_o), 64'(eb));
  endtask

  initial begin
    //              hold redir rpc                     rdy w     req addr                  inst pc                    bub
    vec[0]  = mk(0, 0, 64'h0,                  0, '0,  0, 64'h8000_0000,         NOP, 64'h0,                1);
    vec[1]  = mk(0, 0, 64'h0,                  1, A0,  1, 64'h8000_0000,         NOP, 64'h0,                1);
    vec[2]  = mk(0, 0, 64'h0,                  1, A1,  1, 64'h8000_0004,         A0,  64'h8000_0000,        0);
    vec[3]  = mk(1, 0, 64'h0,                  1, A2,  1, 64'h8000_0008,         A1,  64'h8000_0004,        0);
    vec[4]  = mk(1, 0, 64'h0,                  0, '0,  0, 64'h8000_000C,         A1,  64'h8000_0004,        0);
    vec[5]  = mk(0, 0, 64'h0,                  0, '0,  0, 64'h8000_000C,         A1,  64'h8000_0004,        0);
    vec[6]  = mk(0, 0, 64'h0,                  1, A3,  1, 64'h8000_000C,         A2,  64'h8000_0008,        0);
    vec[7]  = mk(0, 0, 64'h0,                  0, '0,  1, 64'h8000_0010,         A3,  64'h8000_000C,        0);
    vec[8]  = mk(0, 1, 64'h8000_0102,          0, '0,  1, 64'h8000_0010,         NOP, 64'h8000_000C,        1);
    vec[9]  = mk(0, 0, 64'h0,                  0, '0,  0, 64'h8000_0100,         NOP, 64'h8000_000C,        1);
    vec[10] = mk(0, 0, 64'h0,                  1, A0,  0, 64'h8000_0100,         NOP, 64'h8000_000C,        1);
    vec[11] = mk(0, 0, 64'h0,                  1, A1,  1, 64'h8000_0100,         NOP, 64'h8000_000C,        1);
    vec[12] = mk(0, 0, 64'h0,                  0, '0,  1, 64'h8000_0104,         A1,  64'h8000_0100,        0);
    vec[13] = mk(1, 0, 64'h0,                  1, A2,  1, 64'h8000_0104,         NOP, 64'h8000_0100,        1);
    vec[14] = mk(1, 1, 64'h8000_0000,          0, '0,  0, 64'h8000_0108,         NOP, 64'h8000_0100,        1);
    vec[15] = mk(0, 0, 64'h0,                  1, JAL, 1, 64'h8000_0000,         NOP, 64'h8000_0100,        1);
    vec[16] = mk(1, 1, 64'h8000_0203,          1, A3,  1, 64'h8000_0010,         JAL, 64'h8000_0000,        0);
    vec[17] = mk(0, 0, 64'h0,                  1, A0,  1, 64'h8000_0200,         NOP, 64'h8000_0000,        1);
    vec[18] = mk(0, 0, 64'h0,                  0, '0,  1, 64'h8000_0204,         A0,  64'h8000_0200,        0);
    vec[19] = mk(0, 1, 64'hFFFF_FFFF_FFFF_FFFE, 1, A1, 1, 64'h8000_0204,         NOP, 64'h8000_0200,        1);
    vec[20] = mk(0, 0, 64'h0,                  1, A2,  1, TOP,                   NOP, 64'h8000_0200,        1);
    vec[21] = mk(0, 0, 64'h0,                  0, '0,  1, 64'h0,                 A2,  TOP,                  0);
    vec[22] = mk(0, 0, 64'h0,                  0, '0,  1, 64'h0,                 NOP, TOP,                  1);

    #1 reset = 1'b0;
    #2 chk_all(-1, 0, 64'h8000_0000, NOP, 64'h0, 1);
    repeat (2) @(negedge CLK);
    #1 chk_all(-2, 0, 64'h8000_0000, NOP, 64'h0, 1);

    @(negedge CLK);
    reset = 1'b1;
    for (int i = 0; i < NV; i++) begin
      hold_i      = vec[i].hold;
      redirect_en = vec[i].redir;
      redirect_pc = vec[i].rpc;
      imem_ready  = vec[i].rdy;
      imem_rdata  = vec[i].w;
      #1 chk_all(i, vec[i].e_req, vec[i].e_addr, vec[i].e_inst, vec[i].e_pc, vec[i].e_bub);
      @(negedge CLK);
    end

    // Async reset while a request is waiting on memory.
    hold_i = 1'b0; redirect_en = 1'b0; imem_ready = 1'b0; imem_rdata = '0;
    #2 reset = 1'b0;
    #1 chk_all(100, 0, 64'h8000_0000, NOP, 64'h0, 1);
    @(negedge CLK);
    imem_ready = 1'b1; imem_rdata = A3;
    #1 chk_all(101, 0, 64'h8000_0000, NOP, 64'h0, 1);
    @(negedge CLK);
    reset = 1'b1;
    #1 chk_all(102, 0, 64'h8000_0000, NOP, 64'h0, 1);
    @(negedge CLK);
    imem_rdata = A1;
    #1 chk_all(103, 1, 64'h8000_0000, NOP, 64'h0, 1);
    @(negedge CLK);
    imem_ready = 1'b0;
    #1 chk_all(104, 1, 64'h8000_0004, A1, 64'h8000_0000, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
